// File: rtl/text_pkg.sv
// Shared definitions for the text-overlay character buffer: FSM encoding,
// grid geometry and the default clear character.
package text_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  localparam int TXT_COLS  = 16;
  localparam int TXT_ROWS  = 16;
  localparam int TXT_CELLS = TXT_COLS * TXT_ROWS;

  localparam logic [7:0] FILL_CHAR_DEF = 8'h20;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on contention the requester that did not win
// last time is chosen; a lone requester always wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  assign gnt_valid = |req;
  assign gnt_idx   = (&req) ? ~last_gnt : req[1];

endmodule

// File: rtl/text_buf_arbiter.sv
// Write-port controller for the 256-cell character RAM: round-robin between two
// writers, full-screen clear, and optional restriction of writes to vblank.
module text_buf_arbiter #(
  parameter logic [7:0] FILL_CHAR  = text_pkg::FILL_CHAR_DEF,
  parameter bit         SYNC_VBLNK = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vblnk_in,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] addr0,
  input  logic [7:0] addr1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic       ack0,
  output logic       ack1,
  input  logic       clr_req,
  output logic       clr_busy,
  output logic       clr_done,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data
);
  import text_pkg::*;

  localparam logic [7:0] LAST_CELL = 8'(TXT_CELLS - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       pend_q, pend_d;
  logic       last_gnt_q, last_gnt_d;
  logic       wr_en_q, wr_en_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       ack0_q, ack0_d;
  logic       ack1_q, ack1_d;
  logic       clr_busy_q, clr_busy_d;
  logic       clr_done_q, clr_done_d;

  logic ok;
  logic gnt_valid;
  logic gnt_idx;

  assign ok = !SYNC_VBLNK || vblnk_in;

  rr_arb2 u_arb (
    .req       ({req1, req0}),
    .last_gnt  (last_gnt_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    last_gnt_d = last_gnt_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = 8'h00;
    wr_data_d  = 8'h00;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    clr_busy_d = 1'b0;
    clr_done_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // clr_busy stays high through the final clear write, so seeing it in IDLE marks completion.
        clr_done_d = clr_busy_q;
        if ((clr_req || pend_q) && ok) begin
          state_d    = ST_CLEAR;
          cnt_d      = 8'h00;
          pend_d     = 1'b0;
          clr_busy_d = 1'b1;
        end else if (clr_req) begin
          pend_d = 1'b1;
        end else if (gnt_valid && ok) begin
          state_d    = ST_WRITE;
          last_gnt_d = gnt_idx;
          wr_en_d    = 1'b1;
          wr_addr_d  = gnt_idx ? addr1 : addr0;
          wr_data_d  = gnt_idx ? data1 : data0;
          ack0_d     = ~gnt_idx;
          ack1_d     = gnt_idx;
        end
      end

      ST_WRITE: begin
        // Requests are not sampled here, so a req still high during its ack is not rewritten.
        state_d = ST_IDLE;
        if (clr_req) pend_d = 1'b1;
      end

      ST_CLEAR: begin
        clr_busy_d = 1'b1;
        if (ok) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q;
          wr_data_d = FILL_CHAR;
          if (cnt_q == LAST_CELL) state_d = ST_IDLE;
          else                    cnt_d   = cnt_q + 8'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'h00;
      pend_q     <= 1'b0;
      last_gnt_q <= 1'b1;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= 8'h00;
      wr_data_q  <= 8'h00;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      last_gnt_q <= last_gnt_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      clr_busy_q <= clr_busy_d;
      clr_done_q <= clr_done_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign clr_busy = clr_busy_q;
  assign clr_done = clr_done_q;

endmodule

// File: tb/tb_text_buf_arbiter.sv
// Directed bench for text_buf_arbiter: reset, single write, contention,
// blanking gate, full clear with pause, pending clear and async reset.
module tb_text_buf_arbiter;

  logic       clk      = 1'b0;
  logic       rst      = 1'b0;
  logic       vblnk_in = 1'b1;
  logic       req0     = 1'b0;
  logic       req1     = 1'b0;
  logic       clr_req  = 1'b0;
  logic [7:0] addr0    = 8'h00;
  logic [7:0] addr1    = 8'h00;
  logic [7:0] data0    = 8'h00;
  logic [7:0] data1    = 8'h00;
  logic       ack0, ack1, clr_busy, clr_done, wr_en;
  logic [7:0] wr_addr, wr_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  text_buf_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .vblnk_in (vblnk_in),
    .req0     (req0),
    .req1     (req1),
    .addr0    (addr0),
    .addr1    (addr1),
    .data0    (data0),
    .data1    (data1),
    .ack0     (ack0),
    .ack1     (ack1),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  // Observed output vector: {wr_en, wr_addr, wr_data, ack0, ack1, clr_busy, clr_done}
  logic [20:0] obs;
  assign obs = {wr_en, wr_addr, wr_data, ack0, ack1, clr_busy, clr_done};

  localparam logic [20:0] IDLE_O = 21'h0;

  function automatic logic [20:0] ev(input logic en, input logic [7:0] a, input logic [7:0] d,
                                     input logic a0, input logic a1, input logic busy,
                                     input logic done);
    return {en, a, d, a0, a1, busy, done};
  endfunction

  task automatic check(input string tag, input logic [20:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [20:0] BUSY_O = {1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    // Reset state
    repeat (3) tick();
    check("reset", IDLE_O);
    rst = 1'b1;
    tick();
    check("post_reset_idle", IDLE_O);

    // Single write
    req0 = 1'b1; addr0 = 8'h12; data0 = 8'h41;
    tick();
    check("single_wr", ev(1'b1, 8'h12, 8'h41, 1'b1, 1'b0, 1'b0, 1'b0));
    req0 = 1'b0;
    tick();
    check("single_end", IDLE_O);
    tick();
    check("single_once", IDLE_O);

    // Contention: last grant was 0, so requester 1 wins first, then alternate
    addr0 = 8'h30; data0 = 8'hA0; addr1 = 8'h31; data1 = 8'hB1;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if ((i % 2) == 0) check("cont_g1", ev(1'b1, 8'h31, 8'hB1, 1'b0, 1'b1, 1'b0, 1'b0));
      else              check("cont_g0", ev(1'b1, 8'h30, 8'hA0, 1'b1, 1'b0, 1'b0, 1'b0));
      if (i == 3) begin req0 = 1'b0; req1 = 1'b0; end
      tick();
      check("cont_gap", IDLE_O);
    end

    // Blanking gate
    vblnk_in = 1'b0;
    req1 = 1'b1; addr1 = 8'h55; data1 = 8'h66;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("gate_hold", IDLE_O);
    end
    vblnk_in = 1'b1;
    tick();
    check("gate_open", ev(1'b1, 8'h55, 8'h66, 1'b0, 1'b1, 1'b0, 1'b0));
    req1 = 1'b0;
    tick();
    check("gate_end", IDLE_O);

    // Clear beats a same-cycle request; pause after address 100; clr_req mid-clear ignored
    clr_req = 1'b1; req0 = 1'b1; addr0 = 8'h77; data0 = 8'h88;
    tick();
    clr_req = 1'b0;
    check("clr_entry", BUSY_O);
    for (int a = 0; a < 256; a++) begin
      if (a == 10) clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      check("clr_wr", ev(1'b1, 8'(a), 8'h20, 1'b0, 1'b0, 1'b1, 1'b0));
      if (a == 100) begin
        vblnk_in = 1'b0;
        for (int p = 0; p < 5; p++) begin
          tick();
          check("clr_pause", BUSY_O);
        end
        vblnk_in = 1'b1;
      end
    end
    tick();
    check("clr_done_req0", ev(1'b1, 8'h77, 8'h88, 1'b1, 1'b0, 1'b0, 1'b1));
    req0 = 1'b0;
    tick();
    check("after_clr", IDLE_O);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no_reclear", IDLE_O);
    end

    // Clear requested outside blanking is held pending until blanking
    vblnk_in = 1'b0;
    clr_req  = 1'b1;
    tick();
    clr_req = 1'b0;
    check("pend_wait", IDLE_O);
    tick();
    check("pend_wait2", IDLE_O);
    vblnk_in = 1'b1;
    tick();
    check("pend_start", BUSY_O);
    for (int a = 0; a <= 40; a++) begin
      tick();
      check("clr2_wr", ev(1'b1, 8'(a), 8'h20, 1'b0, 1'b0, 1'b1, 1'b0));
    end

    // Asynchronous reset in the middle of the write at address 40
    #2;
    rst = 1'b0;
    #1;
    check("async_reset", IDLE_O);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_idle", IDLE_O);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
